reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement buffer for the out-of-order core. Dispatch allocates one entry per cycle and returns a tag. Execution units mark entries done by tag, possibly out of order. The head entry retires once done. The block produces the `ROB_full` and `MisPredict` signals consumed by the hazard unit, and acts on the `ROB_rollback` signal that the hazard unit returns.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two.
- `TAG_W`, 3: log2(`DEPTH`).
- `PREG_W`, 6: physical register index width.
- `AREG_W`, 5: architectural register index width.
- `XLEN`, 32: PC width.

Ports:
- `clk`  in  1: clock; all state changes on rising edge.
- `rstn`  in  1: synchronous reset, active-low.
- `dp_valid`  in  1: dispatch request.
- `dp_fu`  in  `FU_WIDTH`: functional-unit type of the dispatched op.
- `dp_rd`  in  `AREG_W`: architectural destination.
- `dp_pd_new`  in  `PREG_W`: newly allocated physical destination.
- `dp_pd_old`  in  `PREG_W`: previous mapping of `dp_rd`.
- `dp_tag`  out  `TAG_W`: tag for the current dispatch; equals the tail pointer.
- `ROB_full`  out  1: all entries occupied.
- `rob_empty`  out  1: no entries occupied.
- `wb_valid`  in  1: completion report.
- `wb_tag`  in  `TAG_W`: entry that completed.
- `wb_mispredict`  in  1: completing branch was mispredicted.
- `wb_target`  in  `XLEN`: correct next PC for a mispredicted branch.
- `cm_valid`  out  1: head retires this cycle.
- `cm_rd`, `cm_pd_new`, `cm_pd_old`  out: fields of the retiring entry; `cm_pd_old` is returned to the free list.
- `MisPredict`  out  1: the retiring entry is a mispredicted branch.
- `redirect_pc`  out  `XLEN`: the `wb_target` stored in the head entry.
- `ROB_rollback`  in  1: flush request.

## Operation
- Storage:
  - Per entry: `valid`, `done`, `mispredict`, `fu`, `rd`, `pd_new`, `pd_old`, `target`.
  - Pointers: `head` and `tail`, each `TAG_W` bits, wrapping modulo `DEPTH`.
  - `count`: `TAG_W+1` bits.
- Dispatch: when `dp_valid` and not `ROB_full`, write the entry at `tail` with `done=0`, `mispredict=0`, then increment `tail`. When `dp_valid` and `ROB_full`, the request is ignored.
- Writeback: when `wb_valid` and the entry at `wb_tag` is valid, set `done=1` and latch `mispredict` and `target`. When `wb_valid` targets an invalid entry, the report is ignored.
- Commit (combinational):
  - `cm_valid` = valid(head) & done(head).
  - `cm_*` outputs come from the head entry.
  - `MisPredict` = `cm_valid` & mispredict(head).
  - `redirect_pc` = target(head) whenever `cm_valid`, else 0.
  - On the clock edge, a committing entry is cleared and `head` increments.
- `count` rules:
  - Increments on an accepted dispatch.
  - Decrements on a commit.
  - Unchanged when both occur in the same cycle.
  - `ROB_full` = (`count`==`DEPTH`); `rob_empty` = (`count`==0).
- Full with a commit in the same cycle: a dispatch is still refused. `ROB_full` is evaluated on the current `count`; this rule is conservative and avoids a combinational path.
- Rollback:
  - `ROB_rollback` at an edge clears every `valid` and sets `head`, `tail` and `count` to 0.
  - It overrides any dispatch and writeback in the same cycle.
  - The mispredicted branch retiring in that cycle still presents `cm_valid=1`, so its `pd_old` is freed.
- Reset (`rstn`=0 at an edge) clears state identically to rollback and has priority over it.

## Timing
- Reset values: `dp_tag`=0, `ROB_full`=0, `rob_empty`=1, `cm_valid`=0, `MisPredict`=0, `redirect_pc`=0, all `cm_*` fields 0.
- Dispatch: the entry is visible at the head one cycle after the accepting edge; `dp_tag` is valid in the same cycle as `dp_valid`.
- Completion to retirement: a writeback accepted at edge t lets that entry commit in cycle t+1 at the earliest.
- Throughput: one commit per cycle.
- `MisPredict` asserts for exactly one cycle, because the head is flushed at the next edge by `ROB_rollback`. The hazard unit drives `ROB_rollback` = `MisPredict` in the same cycle.
- Wrap-around: `tail` and `head` roll from `DEPTH-1` to 0 with no bubble.

## Structure
- Add to `defines.vh`: `ROB_DEPTH`, `ROB_TAG_W`, `PREG_W` and `AREG_W` constants alongside the existing `FU_*` encodings. `FU_WIDTH` comes from there.
- Single module with no sub-module. Entry storage is flat register arrays indexed by pointer; there is no RAM macro.

## Test plan
- Reset: hold `rstn`=0 for 2 cycles, then release -> `rob_empty`=1, `ROB_full`=0, `cm_valid`=0, `MisPredict`=0.
- Fill: 8 back-to-back dispatches -> `dp_tag` 0..7; `ROB_full`=1 after the 8th; a 9th dispatch leaves `tail` and `count` unchanged.
- Out-of-order completion: dispatch tags 0,1,2; writeback 2, then 0, then 1 in consecutive cycles -> the commit of 0 occurs one cycle after its writeback, and 1 and 2 commit in the two following cycles, in order.
- Mispredict: dispatch a `FU_BRA` op (tag 0) and an ALU op (tag 1); writeback tag 1, then tag 0 with `wb_mispredict`=1, `wb_target`=0x80 -> one cycle of `MisPredict`=1, `redirect_pc`=0x80, `cm_valid`=1; with `ROB_rollback`=1 the next cycle shows `rob_empty`=1 and tag 1 never commits.
- Wrap: stream 12 dispatch/writeback/commit triples -> tags 0..7 then 0..3; commits occur in dispatch order; `count` never exceeds 8.
- Reset mid-operation: fill to full, then assert `rstn`=0 together with `dp_valid` and `wb_valid` -> next cycle all outputs are at reset values and `dp_tag`=0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer: sizing and functional-unit encodings.
// Imported by the ROB and by anything that builds dispatch bundles for it.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_TAG_W = 3;
    localparam int PREG_W    = 6;
    localparam int AREG_W    = 5;
    localparam int FU_WIDTH  = 3;

    localparam logic [FU_WIDTH-1:0] FU_ALU = 3'd0;
    localparam logic [FU_WIDTH-1:0] FU_MUL = 3'd1;
    localparam logic [FU_WIDTH-1:0] FU_LSU = 3'd2;
    localparam logic [FU_WIDTH-1:0] FU_BRA = 3'd3;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch allocates at tail, writeback marks done
// by tag, the head retires once done. Rollback empties the whole buffer.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int TAG_W  = ROB_TAG_W,
    parameter int PREG_W = reorder_buffer_pkg::PREG_W,
    parameter int AREG_W = reorder_buffer_pkg::AREG_W,
    parameter int XLEN   = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                dp_valid,
    input  logic [FU_WIDTH-1:0] dp_fu,
    input  logic [AREG_W-1:0]   dp_rd,
    input  logic [PREG_W-1:0]   dp_pd_new,
    input  logic [PREG_W-1:0]   dp_pd_old,
    output logic [TAG_W-1:0]    dp_tag,
    output logic                ROB_full,
    output logic                rob_empty,
    input  logic                wb_valid,
    input  logic [TAG_W-1:0]    wb_tag,
    input  logic                wb_mispredict,
    input  logic [XLEN-1:0]     wb_target,
    output logic                cm_valid,
    output logic [AREG_W-1:0]   cm_rd,
    output logic [PREG_W-1:0]   cm_pd_new,
    output logic [PREG_W-1:0]   cm_pd_old,
    output logic                MisPredict,
    output logic [XLEN-1:0]     redirect_pc,
    input  logic                ROB_rollback
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]    valid_q;
    logic [DEPTH-1:0]    done_q;
    logic [DEPTH-1:0]    misp_q;
    logic [FU_WIDTH-1:0] fu_q     [DEPTH];
    logic [AREG_W-1:0]   rd_q     [DEPTH];
    logic [PREG_W-1:0]   pd_new_q [DEPTH];
    logic [PREG_W-1:0]   pd_old_q [DEPTH];
    logic [XLEN-1:0]     target_q [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    logic dp_fire;
    logic wb_fire;

    assign ROB_full  = (count == FULL_CNT);
    assign rob_empty = (count == '0);
    assign dp_tag    = tail;

    // Full is judged on the current count only, so a same-cycle commit
    // never opens a slot combinationally.
    assign dp_fire = dp_valid & ~ROB_full;
    assign wb_fire = wb_valid & valid_q[wb_tag];

    assign cm_valid    = valid_q[head] & done_q[head];
    assign cm_rd       = rd_q[head];
    assign cm_pd_new   = pd_new_q[head];
    assign cm_pd_old   = pd_old_q[head];
    assign MisPredict  = cm_valid & misp_q[head];
    assign redirect_pc = cm_valid ? target_q[head] : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '0;
            done_q  <= '0;
            misp_q  <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fu_q[i]     <= '0;
                rd_q[i]     <= '0;
                pd_new_q[i] <= '0;
                pd_old_q[i] <= '0;
                target_q[i] <= '0;
            end
        end else if (ROB_rollback) begin
            valid_q <= '0;
            done_q  <= '0;
            misp_q  <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (wb_fire) begin
                done_q[wb_tag]   <= 1'b1;
                misp_q[wb_tag]   <= wb_mispredict;
                target_q[wb_tag] <= wb_target;
            end
            if (cm_valid) begin
                valid_q[head] <= 1'b0;
                done_q[head]  <= 1'b0;
                misp_q[head]  <= 1'b0;
                head          <= head + 1'b1;
            end
            if (dp_fire) begin
                valid_q[tail]  <= 1'b1;
                done_q[tail]   <= 1'b0;
                misp_q[tail]   <= 1'b0;
                fu_q[tail]     <= dp_fu;
                rd_q[tail]     <= dp_rd;
                pd_new_q[tail] <= dp_pd_new;
                pd_old_q[tail] <= dp_pd_old;
                tail           <= tail + 1'b1;
            end
            case ({dp_fire, cm_valid})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with an in-order commit scoreboard.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int XLEN = 32;
    localparam int TW   = ROB_TAG_W;

    typedef struct packed {
        logic [AREG_W-1:0] rd;
        logic [PREG_W-1:0] pn;
        logic [PREG_W-1:0] po;
    } ent_t;

    logic                clk;
    logic                rstn;
    logic                dp_valid;
    logic [FU_WIDTH-1:0] dp_fu;
    logic [AREG_W-1:0]   dp_rd;
    logic [PREG_W-1:0]   dp_pd_new;
    logic [PREG_W-1:0]   dp_pd_old;
    logic [TW-1:0]       dp_tag;
    logic                ROB_full;
    logic                rob_empty;
    logic                wb_valid;
    logic [TW-1:0]       wb_tag;
    logic                wb_mispredict;
    logic [XLEN-1:0]     wb_target;
    logic                cm_valid;
    logic [AREG_W-1:0]   cm_rd;
    logic [PREG_W-1:0]   cm_pd_new;
    logic [PREG_W-1:0]   cm_pd_old;
    logic                MisPredict;
    logic [XLEN-1:0]     redirect_pc;
    logic                ROB_rollback;

    ent_t q[$];
    int   total;
    int   bad;
    int   seq;

    reorder_buffer dut (
        .clk          (clk),
        .rstn         (rstn),
        .dp_valid     (dp_valid),
        .dp_fu        (dp_fu),
        .dp_rd        (dp_rd),
        .dp_pd_new    (dp_pd_new),
        .dp_pd_old    (dp_pd_old),
        .dp_tag       (dp_tag),
        .ROB_full     (ROB_full),
        .rob_empty    (rob_empty),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_mispredict(wb_mispredict),
        .wb_target    (wb_target),
        .cm_valid     (cm_valid),
        .cm_rd        (cm_rd),
        .cm_pd_new    (cm_pd_new),
        .cm_pd_old    (cm_pd_old),
        .MisPredict   (MisPredict),
        .redirect_pc  (redirect_pc),
        .ROB_rollback (ROB_rollback)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        dp_valid      = 1'b0;
        wb_valid      = 1'b0;
        wb_tag        = '0;
        wb_mispredict = 1'b0;
        wb_target     = '0;
        ROB_rollback  = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic drive_dp(input logic [FU_WIDTH-1:0] fu, input bit accept);
        dp_valid  = 1'b1;
        dp_fu     = fu;
        dp_rd     = AREG_W'(seq * 3 + 1);
        dp_pd_new = PREG_W'(seq + 17);
        dp_pd_old = PREG_W'(seq * 5 + 2);
        seq++;
        if (accept) q.push_back('{rd: dp_rd, pn: dp_pd_new, po: dp_pd_old});
    endtask

    task automatic drive_wb(input int t, input logic m, input logic [XLEN-1:0] tgt);
        wb_valid      = 1'b1;
        wb_tag        = TW'(t);
        wb_mispredict = m;
        wb_target     = tgt;
    endtask

    task automatic exp_commit(input string name);
        ent_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=commit expected=empty_scoreboard", name);
        end else begin
            e = q.pop_front();
            chk({name, "_valid"}, 64'(cm_valid), 64'd1);
            chk({name, "_rd"}, 64'(cm_rd), 64'(e.rd));
            chk({name, "_pd_new"}, 64'(cm_pd_new), 64'(e.pn));
            chk({name, "_pd_old"}, 64'(cm_pd_old), 64'(e.po));
        end
    endtask

    task automatic do_reset();
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        q.delete();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        seq   = 0;
        idle();
        rstn      = 1'b0;
        dp_fu     = '0;
        dp_rd     = '0;
        dp_pd_new = '0;
        dp_pd_old = '0;

        // reset held for two rising edges
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_empty", 64'(rob_empty), 64'd1);
        chk("rst_full", 64'(ROB_full), 64'd0);
        chk("rst_cm_valid", 64'(cm_valid), 64'd0);
        chk("rst_mispredict", 64'(MisPredict), 64'd0);
        chk("rst_tag", 64'(dp_tag), 64'd0);
        chk("rst_redirect", 64'(redirect_pc), 64'd0);

        // fill
        for (int i = 0; i < 8; i++) begin
            step();
            drive_dp(FU_ALU, 1'b1);
            #1;
            chk("fill_tag", 64'(dp_tag), 64'(i));
            chk("fill_full", 64'(ROB_full), 64'd0);
        end
        step();
        drive_dp(FU_ALU, 1'b0);
        #1;
        chk("full_set", 64'(ROB_full), 64'd1);
        chk("full_tag", 64'(dp_tag), 64'd0);
        chk("full_not_empty", 64'(rob_empty), 64'd0);
        step();
        #1;
        chk("ninth_full", 64'(ROB_full), 64'd1);
        chk("ninth_tag", 64'(dp_tag), 64'd0);

        // drain in order; dispatch attempted while full and committing
        for (int k = 0; k < 9; k++) begin
            step();
            if (k < 8) drive_wb(k, 1'b0, '0);
            if (k == 1) drive_dp(FU_ALU, 1'b0);
            #1;
            if (k == 0) chk("drain_first", 64'(cm_valid), 64'd0);
            else exp_commit("drain");
            if (k == 1) chk("full_commit_refuse", 64'(ROB_full), 64'd1);
        end
        step();
        #1;
        chk("drain_empty", 64'(rob_empty), 64'd1);
        chk("drain_cm_valid", 64'(cm_valid), 64'd0);
        chk("drain_tag", 64'(dp_tag), 64'd0);

        // out-of-order completion
        for (int i = 0; i < 3; i++) begin
            step();
            drive_dp(FU_ALU, 1'b1);
            #1;
            chk("ooo_tag", 64'(dp_tag), 64'(i));
        end
        step();
        drive_wb(2, 1'b0, '0);
        #1;
        chk("ooo_wait0", 64'(cm_valid), 64'd0);
        step();
        drive_wb(0, 1'b0, '0);
        #1;
        chk("ooo_wait1", 64'(cm_valid), 64'd0);
        step();
        drive_wb(1, 1'b0, '0);
        #1;
        exp_commit("ooo_c0");
        step();
        #1;
        exp_commit("ooo_c1");
        step();
        #1;
        exp_commit("ooo_c2");
        step();
        #1;
        chk("ooo_idle", 64'(cm_valid), 64'd0);
        chk("ooo_empty", 64'(rob_empty), 64'd1);

        // mispredicted branch with rollback
        do_reset();
        step();
        drive_dp(FU_BRA, 1'b1);
        #1;
        chk("mp_tag0", 64'(dp_tag), 64'd0);
        step();
        drive_dp(FU_ALU, 1'b1);
        #1;
        chk("mp_tag1", 64'(dp_tag), 64'd1);
        step();
        drive_wb(1, 1'b0, '0);
        #1;
        chk("mp_wait0", 64'(cm_valid), 64'd0);
        step();
        drive_wb(0, 1'b1, 32'h80);
        #1;
        chk("mp_wait1", 64'(cm_valid), 64'd0);
        chk("mp_wait1_mp", 64'(MisPredict), 64'd0);
        step();
        #1;
        exp_commit("mp_commit");
        chk("mp_flag", 64'(MisPredict), 64'd1);
        chk("mp_redirect", 64'(redirect_pc), 64'h80);
        ROB_rollback = MisPredict;
        step();
        #1;
        chk("rb_empty", 64'(rob_empty), 64'd1);
        chk("rb_cm_valid", 64'(cm_valid), 64'd0);
        chk("rb_flag", 64'(MisPredict), 64'd0);
        chk("rb_redirect", 64'(redirect_pc), 64'd0);
        chk("rb_tag", 64'(dp_tag), 64'd0);
        q.delete();

        // writeback to an empty slot is dropped
        drive_wb(0, 1'b1, 32'h44);
        step();
        drive_dp(FU_ALU, 1'b1);
        #1;
        chk("stale_wb_tag", 64'(dp_tag), 64'd0);
        step();
        #1;
        chk("stale_wb_nocommit", 64'(cm_valid), 64'd0);
        chk("stale_wb_nonempty", 64'(rob_empty), 64'd0);
        step();
        drive_wb(0, 1'b0, '0);
        #1;
        chk("late_wait", 64'(cm_valid), 64'd0);
        step();
        #1;
        exp_commit("late_commit");
        chk("late_flag", 64'(MisPredict), 64'd0);
        chk("late_redirect", 64'(redirect_pc), 64'd0);

        // wrap-around stream
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step();
            if (i < 12) drive_dp(FU_ALU, 1'b1);
            if (i >= 1 && i <= 12) drive_wb((i - 1) % 8, 1'b0, '0);
            #1;
            if (i < 12) chk("wrap_tag", 64'(dp_tag), 64'(i % 8));
            chk("wrap_full", 64'(ROB_full), 64'd0);
            if (i >= 2) exp_commit("wrap");
            else chk("wrap_idle", 64'(cm_valid), 64'd0);
        end
        step();
        #1;
        chk("wrap_empty", 64'(rob_empty), 64'd1);

        // reset in the middle of a full buffer
        for (int i = 0; i < 8; i++) begin
            step();
            drive_dp(FU_ALU, 1'b1);
        end
        step();
        rstn = 1'b0;
        drive_dp(FU_ALU, 1'b0);
        drive_wb(0, 1'b1, 32'hdead);
        #1;
        chk("mid_full", 64'(ROB_full), 64'd1);
        step();
        rstn = 1'b1;
        q.delete();
        #1;
        chk("mid_tag", 64'(dp_tag), 64'd0);
        chk("mid_full_clr", 64'(ROB_full), 64'd0);
        chk("mid_empty", 64'(rob_empty), 64'd1);
        chk("mid_cm_valid", 64'(cm_valid), 64'd0);
        chk("mid_flag", 64'(MisPredict), 64'd0);
        chk("mid_redirect", 64'(redirect_pc), 64'd0);
        chk("mid_rd", 64'(cm_rd), 64'd0);
        chk("mid_pd_new", 64'(cm_pd_new), 64'd0);
        chk("mid_pd_old", 64'(cm_pd_old), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
